// File: rtl/segment_scan_if.sv
// Load handshake for segment_scan: a packed BCD word qualified by valid, accepted on ready.
interface segment_scan_if #(
  parameter int DIGITS = 8
);
  logic                i_valid;
  logic [4*DIGITS-1:0] i_data;
  logic                o_ready;

  modport master (output i_valid, output i_data, input o_ready);
  modport slave  (input i_valid, input i_data, output o_ready);
endinterface

// File: rtl/segment_scan.sv
// Time-multiplexed common-anode 7-segment scanner: a double-buffered BCD word is
// walked one digit per slot, with per-slot dead time and leading-zero blanking.
module segment_scan #(
  parameter int DIGITS = 8,
  parameter int DIV    = 100000,
  parameter int BLANK  = 16,
  parameter int LZB    = 1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  segment_scan_if.slave     bus,
  output logic [7:0]        o_digit,
  output logic [DIGITS-1:0] o_an,
  output logic              o_frame
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
  localparam logic [PW-1:0] DEAD_END   = PW'(BLANK);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(DIGITS - 1);
  localparam logic [7:0]    DIGIT_OFF  = 8'h0F;

  logic [PW-1:0]       prescaler;
  logic [SW-1:0]       slot;
  logic [4*DIGITS-1:0] active;
  logic [4*DIGITS-1:0] pending;
  logic                ready;

  logic                slot_end;
  logic                frame_end;
  logic                take;
  logic                dead;
  logic                lz_blank;
  logic [SW-1:0]       top_nz;
  logic [3:0]          cur_bcd;
  logic [7:0]          digit_next;
  logic [DIGITS-1:0]   an_next;

  assign slot_end    = (prescaler == PRESC_LAST);
  assign frame_end   = slot_end && (slot == SLOT_LAST);
  assign take        = bus.i_valid && ready;
  assign dead        = (prescaler < DEAD_END);
  assign bus.o_ready = ready;

  // Index of the most significant nonzero digit; stays 0 for an all-zero word,
  // which keeps digit 0 visible.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    top_nz = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (active[4*i +: 4] != 4'h0) top_nz = SW'(i);
    end
  end

  assign cur_bcd  = active[4*slot +: 4];
  assign lz_blank = (LZB != 0) && (slot > top_nz);

  always_comb begin
    digit_next = {4'h0, cur_bcd};
    an_next    = ~(DIGITS'(1) << slot);
    if (dead) begin
      digit_next = DIGIT_OFF;
      an_next    = '1;
    end else if (lz_blank) begin
      digit_next = DIGIT_OFF;
    end
  end

  // A load and a frame boundary cannot both move pending: a boundary only
  // promotes when pending is full, and a load only lands when it is empty.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments only; reset is synchronous,
    // and both display buffers are cleared so a mid-frame reset leaves nothing stale.
    if (!i_rst_n) begin
      prescaler <= '0;
      slot      <= '0;
      active    <= '0;
      pending   <= '0;
      ready     <= 1'b1;
      o_digit   <= DIGIT_OFF;
      o_an      <= '1;
      o_frame   <= 1'b0;
    end else begin
      prescaler <= slot_end ? '0 : prescaler + 1'b1;
      if (slot_end) slot <= (slot == SLOT_LAST) ? '0 : slot + 1'b1;
      if (take) begin
        pending <= bus.i_data;
        ready   <= 1'b0;
      end else if (frame_end && !ready) begin
        active <= pending;
        ready  <= 1'b1;
      end
      o_digit <= digit_next;
      o_an    <= an_next;
      o_frame <= frame_end;
    end
  end

endmodule
